// File: rtl/l2_arbiter.sv
// Two-requester (icache/dcache) arbiter for a single L2 beat port.
// Round-robin on ties, with a beat quota that forces handover when the other side waits.
package l2_arbiter_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_req_valid,
  input  logic              dcache_req_valid,
  input  memory_operation_e icache_req_type,
  input  memory_operation_e dcache_req_type,
  input  logic [ADDR_W-1:0] icache_req_address,
  input  logic [ADDR_W-1:0] dcache_req_address,
  input  logic [DATA_W-1:0] icache_req_wdata,
  input  logic [DATA_W-1:0] dcache_req_wdata,
  output logic              icache_req_fulfilled,
  output logic              dcache_req_fulfilled,
  output logic              icache_grant,
  output logic              dcache_grant,
  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [ADDR_W-1:0] l2_req_address,
  output logic [DATA_W-1:0] l2_req_wdata,
  input  logic              l2_req_fulfilled,
  input  logic [DATA_W-1:0] l2_rdata,
  output logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2
  } state_e;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BEATS);

  state_e     state_q, state_d;
  logic [7:0] count_q, count_d;
  logic       last_d_q, last_d_d;  // 1: dcache held the most recent grant

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      last_d_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      last_d_q <= last_d_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    last_d_d = last_d_q;
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (icache_req_valid && dcache_req_valid)
          state_d = last_d_q ? ST_GRANT_I : ST_GRANT_D;
        else if (icache_req_valid)
          state_d = ST_GRANT_I;
        else if (dcache_req_valid)
          state_d = ST_GRANT_D;
      end
      ST_GRANT_I: begin
        if (!icache_req_valid) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b0;
          count_d  = '0;
        end else if (l2_req_fulfilled) begin
          if (count_q < MAX_CNT) count_d = count_q + 8'd1;
          // Quota check also covers an already-saturated count.
          if (dcache_req_valid && count_q >= MAX_CNT - 8'd1) begin
            state_d  = ST_GRANT_D;
            last_d_d = 1'b0;
            count_d  = '0;
          end
        end
      end
      ST_GRANT_D: begin
        if (!dcache_req_valid) begin
          state_d  = ST_IDLE;
          last_d_d = 1'b1;
          count_d  = '0;
        end else if (l2_req_fulfilled) begin
          if (count_q < MAX_CNT) count_d = count_q + 8'd1;
          if (icache_req_valid && count_q >= MAX_CNT - 8'd1) begin
            state_d  = ST_GRANT_I;
            last_d_d = 1'b1;
            count_d  = '0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase
  end

  always_comb begin
    icache_grant         = 1'b0;
    dcache_grant         = 1'b0;
    icache_req_fulfilled = 1'b0;
    dcache_req_fulfilled = 1'b0;
    l2_req_valid         = 1'b0;
    l2_req_type          = LOAD;
    l2_req_address       = '0;
    l2_req_wdata         = '0;
    if (reset) begin
      case (state_q)
        ST_IDLE: ;
        ST_GRANT_I: begin
          icache_grant         = 1'b1;
          l2_req_valid         = icache_req_valid;
          l2_req_type          = icache_req_type;
          l2_req_address       = icache_req_address;
          l2_req_wdata         = icache_req_wdata;
          icache_req_fulfilled = l2_req_fulfilled & icache_req_valid;
        end
        ST_GRANT_D: begin
          dcache_grant         = 1'b1;
          l2_req_valid         = dcache_req_valid;
          l2_req_type          = dcache_req_type;
          l2_req_address       = dcache_req_address;
          l2_req_wdata         = dcache_req_wdata;
          dcache_req_fulfilled = l2_req_fulfilled & dcache_req_valid;
        end
        default: begin
          icache_grant         = 1'bx;
          dcache_grant         = 1'bx;
          icache_req_fulfilled = 1'bx;
          dcache_req_fulfilled = 1'bx;
          l2_req_valid         = 1'bx;
          l2_req_type          = memory_operation_e'(1'bx);
          l2_req_address       = 'x;
          l2_req_wdata         = 'x;
        end
      endcase
    end
  end

  assign rdata = l2_rdata;

endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL take parameter ADDR_W, default 32, request address width.
REQ-002 SHALL take parameter DATA_W, default 32, request data width.
REQ-003 SHALL take parameter MAX_BEATS, default 16, fulfilled beats per grant before a forced handover when the other requester waits; legal range 1..255.
REQ-004 SHALL have port: clk  input  1  sole clock; all state changes on posedge.
REQ-005 SHALL have port: reset  input  1  synchronous, active-low (0 = reset).
REQ-006 SHALL have ports: icache_req_valid / dcache_req_valid  input  1  each  requester wants an L2 beat.
REQ-007 SHALL have ports: icache_req_type / dcache_req_type  input  memory_operation_e  LOAD or STORE.
REQ-008 SHALL have ports: icache_req_address / dcache_req_address  input  ADDR_W  beat address.
REQ-009 SHALL have ports: icache_req_wdata / dcache_req_wdata  input  DATA_W  store data.
REQ-010 SHALL have ports: icache_req_fulfilled / dcache_req_fulfilled  output  1  beat completion returned to each requester.
REQ-011 SHALL have ports: icache_grant / dcache_grant  output  1  each  requester currently owns the L2 port.
REQ-012 SHALL have ports: l2_req_valid  output  1;  l2_req_type  output  memory_operation_e;  l2_req_address  output  ADDR_W;  l2_req_wdata  output  DATA_W.
REQ-013 SHALL have port: l2_req_fulfilled  input  1  L2 completed the current beat.
REQ-014 SHALL have ports: l2_rdata  input  DATA_W;  rdata  output  DATA_W, equal to l2_rdata at all times, broadcast to both requesters.

Function
REQ-015 SHALL implement states ST_IDLE, ST_GRANT_I and ST_GRANT_D; any other encoding SHALL drive all outputs to X.
REQ-016 SHALL leave ST_IDLE only when some requester is valid: one valid requester -> its GRANT state; both valid -> the requester not in last_grant.
REQ-017 SHALL assert no grant and l2_req_valid=0 in ST_IDLE, giving a fixed one-cycle arbitration latency from req_valid to l2_req_valid.
REQ-018 SHALL make outputs in ST_GRANT_x Moore: x_grant=1; l2_req_type/address/wdata = requester x inputs; l2_req_valid = x_req_valid.
REQ-019 SHALL drive l2_req_type=LOAD, l2_req_address=0 and l2_req_wdata=0 when not granted.
REQ-020 SHALL assert x_req_fulfilled = l2_req_fulfilled AND l2_req_valid in ST_GRANT_x, in the same cycle; the non-granted requester's fulfilled SHALL stay 0.
REQ-021 SHALL ignore l2_req_fulfilled when l2_req_valid=0.
REQ-022 SHALL keep an 8-bit beat counter: cleared on grant entry, incremented on each forwarded fulfilled beat, saturating at MAX_BEATS.
REQ-023 SHALL transition from ST_GRANT_x with priority (a) x_req_valid=0 -> ST_IDLE; (b) a fulfilled beat raising the count to MAX_BEATS while the other requester is valid -> other GRANT state directly, count cleared; (c) otherwise stay.
REQ-024 SHALL hold the grant when the count reaches MAX_BEATS with no other requester waiting, and SHALL hand over on the next fulfilled beat on which the other requester is valid.
REQ-025 SHALL set last_grant to the owner whenever a GRANT state is exited.
REQ-026 SHALL end the grant as in REQ-023(a) if the requester drops valid before fulfilled; this is a requester protocol violation and no beat SHALL be counted.
REQ-027 SHALL never grant both requesters in one cycle and SHALL never assert both fulfilled outputs in one cycle.

Reset
REQ-028 SHALL, with reset=0 at posedge, load state=ST_IDLE, count=0 and last_grant=DCACHE so ICACHE wins the first tie.
REQ-029 SHALL hold all outputs other than rdata at 0/LOAD while in reset.
REQ-030 SHALL drop l2_req_valid the cycle after reset is asserted mid-transaction and SHALL abandon the beat; L2 SHALL also be reset.

Verification
REQ-031 SHALL be verified by: post-reset, both valid in the same cycle -> icache_grant=1 one cycle later; after icache drops valid -> IDLE, dcache granted next.
REQ-032 SHALL be verified by: dcache alone streaming 16 STORE beats, L2 fulfilling each cycle -> 16 dcache_req_fulfilled pulses, l2_req_type=STORE, no icache activity.
REQ-033 SHALL be verified by: dcache holding valid for 20 beats, icache valid from beat 3, MAX_BEATS=16 -> handover to icache immediately after the 16th fulfilled beat, with no IDLE cycle.
REQ-034 SHALL be verified by: l2_req_fulfilled pulsed while in IDLE -> both fulfilled outputs stay 0 and the count is unchanged.
REQ-035 SHALL be verified by: reset=0 asserted mid-burst with address 0x40 -> l2_req_valid=0 and l2_req_address=0 the next cycle, state IDLE.
REQ-036 SHALL be verified by an assertion running across all tests: the grants are one-hot-or-zero and each fulfilled output is 0 without its matching grant.
